// File: rtl/rangefinder_pkg.sv
// Shared constants and helpers for the rangefinder pushbutton front end.
// Holds the clock rate, the debounce window and the sizing functions.
package rangefinder_pkg;

  localparam int DEFAULT_BTN_WIDTH = 6;
  localparam longint CLK_HZ        = 50_000_000;
  localparam int DEBOUNCE_MS       = 10;

  function automatic int ms_to_cycles(input int ms);
    return int'((CLK_HZ * longint'(ms)) / 1000);
  endfunction

  // Returns the bit count needed to hold the values 0 .. v-1.
  function automatic int clog2(input longint v);
    int bits;
    longint span;
    bits = 0;
    span = 1;
    while (span < v) begin
      span = span << 1;
      bits++;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

  localparam int DEFAULT_DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, saturating debounce counter,
// stable level register and registered press/release strobes.
module debounce_channel
  import rangefinder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,      // already normalised: 1 = pressed
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;

  // NOTE: every output of this block gets a default on the first lines so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cnt_d     = '0;
    stable_d  = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    accept    = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_LIMIT) begin
        accept    = 1'b1;
        stable_d  = s2_q;
        press_d   = s2_q;
        release_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so the synchronizer
  // chain shifts by exactly one stage per edge regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/rangefinder_button_debouncer.sv
// Debounces the raw board pushbuttons into a clean active-high level bus for
// the buttons PIO plus one-cycle press/release strobes.
module rangefinder_button_debouncer
  import rangefinder_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_BTN_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  // Inverting ahead of the synchronizer is equivalent to inverting after it:
  // the sync flops then reset to 0, which is the released value in this domain.
  logic [WIDTH-1:0] btn_norm;
  assign btn_norm = btn_raw ^ {WIDTH{ACTIVE_LOW}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn_i    (btn_norm[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_rangefinder_button_debouncer.sv
// Scoreboard bench: stimulus pushes expected strobe events, a negedge monitor
// pops and compares them; an ACTIVE_LOW=0 twin gets inverted pads.
module tb_rangefinder_button_debouncer;

  localparam int W  = 6;
  localparam int DC = 8;

  typedef struct {
    int         cyc;
    logic [W-1:0] press;
    logic [W-1:0] rel;
    logic [W-1:0] level;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] raw_l = '1;
  logic [W-1:0] raw_h;
  logic [W-1:0] level_l, press_l, rel_l;
  logic [W-1:0] level_h, press_h, rel_h;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [W-1:0] exp_level = '0;

  assign raw_h = ~raw_l;

  rangefinder_button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .reset(reset), .btn_raw(raw_l),
    .btn_level(level_l), .btn_press(press_l), .btn_release(rel_l)
  );

  rangefinder_button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .reset(reset), .btn_raw(raw_h),
    .btn_level(level_h), .btn_press(press_h), .btn_release(rel_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A pad change made now is sampled on the next edge; the strobe follows
  // DC+1 edges later, i.e. it is visible after edge cyc+DC+2.
  task automatic expect_event(input int at, input logic [W-1:0] p, input logic [W-1:0] r);
    exp_t e;
    exp_level = (exp_level | p) & ~r;
    e.cyc   = at;
    e.press = p;
    e.rel   = r;
    e.level = exp_level;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("polarity_twin", {26'd0, level_h}, {26'd0, level_l});
    check("polarity_twin_strobes", {20'd0, press_h, rel_h}, {20'd0, press_l, rel_l});
    if ((|press_l) || (|rel_l)) begin
      check("press_release_exclusive", {26'd0, press_l & rel_l}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {20'd0, press_l, rel_l}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("btn_press", {26'd0, press_l}, {26'd0, e.press});
        check("btn_release", {26'd0, rel_l}, {26'd0, e.rel});
        check("btn_level", {26'd0, level_l}, {26'd0, e.level});
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      check("missing_strobe_cycle", cyc, e.cyc);
    end
  end

  initial begin
    // Reset with all pads released, then idle for 100 cycles.
    tick(3);
    check("reset_level", {26'd0, level_l}, 32'd0);
    check("reset_press", {26'd0, press_l}, 32'd0);
    check("reset_release", {26'd0, rel_l}, 32'd0);
    reset = 1'b0;
    tick(100);
    check("idle_level", {26'd0, level_l}, 32'd0);

    // Single clean press on bit 0, held.
    raw_l[0] = 1'b0;
    expect_event(cyc + DC + 2, 6'b000001, '0);
    tick(20);
    check("press0_level", {26'd0, level_l}, 32'h01);

    // Bounce on bit 2: 3-cycle runs never accumulate to DC.
    for (int i = 0; i < 40; i++) begin
      raw_l[2] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    raw_l[2] = 1'b0;
    expect_event(cyc + DC + 2, 6'b000100, '0);
    tick(20);

    // Glitch on bit 5: 7 cycles low is ignored, 8 cycles is accepted.
    raw_l[5] = 1'b0;
    tick(7);
    raw_l[5] = 1'b1;
    tick(20);
    check("glitch_level", {26'd0, level_l}, 32'h05);
    raw_l[5] = 1'b0;
    expect_event(cyc + DC + 2, 6'b100000, '0);
    tick(8);
    raw_l[5] = 1'b1;
    expect_event(cyc + DC + 2, '0, 6'b100000);
    tick(25);

    // Bits 1 and 3 pressed and released together.
    raw_l[1] = 1'b0;
    raw_l[3] = 1'b0;
    expect_event(cyc + DC + 2, 6'b001010, '0);
    tick(15);
    check("simul_level", {26'd0, level_l}, 32'h0F);
    raw_l[1] = 1'b1;
    raw_l[3] = 1'b1;
    expect_event(cyc + DC + 2, '0, 6'b001010);
    tick(15);

    // Bit 4 pressed, reset asserted once its counter has reached 5.
    raw_l[4] = 1'b0;
    tick(7);
    reset = 1'b1;
    #1;
    check("midreset_level", {26'd0, level_l}, 32'd0);
    check("midreset_level_twin", {26'd0, level_h}, 32'd0);
    check("midreset_queue", sb.size(), 32'd0);
    exp_level = '0;
    tick(2);
    reset = 1'b0;
    // Bits 0, 2 and 4 are still held and are all re-accepted together.
    expect_event(cyc + DC + 2, 6'b010101, '0);
    tick(9);
    check("reaccept_not_early", {26'd0, level_l}, 32'd0);
    tick(10);
    check("reaccept_level", {26'd0, level_l}, 32'h15);

    tick(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_level", {26'd0, level_l}, {26'd0, exp_level});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
